map_table: RTL and testbench
============================

MAP_TABLE -- requirements
Module: map_table

Interface
REQ-001 SHALL have parameters: NUM_AREGS, default 32, number of architectural registers; NUM_PREGS, default 64, number of physical registers; PREG_W, default 6, physical tag width; AREG_W, default 5, architectural index width.
REQ-002 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port rename_valid, input, [1:0], slot i renames this cycle; slot 0 is older.
REQ-005 SHALL have port dest_areg, input, [1:0][AREG_W], destination architectural register per slot.
REQ-006 SHALL have ports src1_areg and src2_areg, input, [1:0][AREG_W], source architectural registers per slot.
REQ-007 SHALL have port new_preg, input, [1:0][PREG_W], free-list grants; new_preg[i] is consumed only when rename_valid[i]=1 and dest_areg[i]!=0.
REQ-008 SHALL have ports src1_preg and src2_preg, output, [1:0][PREG_W], renamed source tags, combinational.
REQ-009 SHALL have ports src1_ready and src2_ready, output, [1:0], source value already available, combinational.
REQ-010 SHALL have port told_preg, output, [1:0][PREG_W], previous mapping of dest_areg[i], sent to ROB, combinational.
REQ-011 SHALL have ports cdb_valid, input, 1, and cdb_preg, input, PREG_W, completion broadcast.
REQ-012 SHALL have ports retire_valid, input, [1:0], retire_areg, input, [1:0][AREG_W], and retire_preg, input, [1:0][PREG_W], in-order commit updates.
REQ-013 SHALL have port rewind, input, 1, flush of all speculative state.

Function
REQ-014 SHALL hold a speculative table SPEC[NUM_AREGS] of {preg, ready} and an architectural table ARCH[NUM_AREGS] of preg.
REQ-015 Lookup: srcN_preg[i] SHALL equal SPEC[srcN_areg[i]].preg; srcN_ready[i] SHALL equal SPEC ready bit, or 1 when cdb_valid and cdb_preg matches that tag.
REQ-016 Intra-group: if rename_valid[0], dest_areg[0]!=0 and srcN_areg[1]==dest_areg[0], slot 1 SHALL output srcN_preg[1]=new_preg[0], srcN_ready[1]=0.
REQ-017 told_preg[0] SHALL equal SPEC[dest_areg[0]].preg; told_preg[1] SHALL equal new_preg[0] when slot 0 is valid and dest_areg[1]==dest_areg[0]!=0, else SPEC[dest_areg[1]].preg.
REQ-018 Areg 0 SHALL always read preg 0 with ready=1; dest_areg 0 SHALL write nothing and report told_preg 0.
REQ-019 On a valid rename, SPEC[dest] SHALL become {new_preg, ready=0} at the next edge; when both slots write the same areg, slot 1 SHALL win.
REQ-020 On cdb_valid, every SPEC entry whose preg equals cdb_preg SHALL set ready=1 at the next edge; a rename to the same preg in the same cycle SHALL leave ready=0.
REQ-021 On retire_valid[i] with retire_areg!=0, ARCH[retire_areg[i]] SHALL become retire_preg[i]; when both slots retire the same areg, slot 1 SHALL win.
REQ-022 On rewind, SPEC SHALL become ARCH including same-cycle retire updates, with all ready=1; renames and CDB updates in that cycle SHALL be ignored; lookup outputs in the rewind cycle are don't-care.
REQ-023 Combinational lookup latency SHALL be 0 cycles; writes SHALL be visible to lookups 1 cycle later.
REQ-024 SHALL have no internal FSM beyond table state; the block SHALL never stall.

Reset
REQ-025 On reset, SPEC[i] SHALL become {preg=i, ready=1} and ARCH[i] SHALL become i for all i, matching the free list reset state where pregs 0..NUM_AREGS-1 are allocated.
REQ-026 Reset SHALL override rewind, rename, retire and CDB in the same cycle.
REQ-027 After reset deasserts, outputs SHALL reflect the reset tables on the first cycle.

Verification
REQ-028 Reset, then look up r5 -> src1_preg=5, src1_ready=1.
REQ-029 Slot 0 renames r3 with new_preg 40; slot 1 reads r3 and renames r3 with new_preg 41 -> slot 1 src1_preg=40, ready=0, told_preg[0]=3, told_preg[1]=40; next cycle r3 maps to 41.
REQ-030 r7 is renamed to p50; CDB p50 the next cycle -> same-cycle read of r7 gives ready=1; after that edge SPEC ready=1.
REQ-031 Rename r4 to p45, retire r4 to p45, rename r4 to p46, then rewind -> r4 reads p45 with ready=1.
REQ-032 Rename with dest_areg 0 and src 0 -> src_preg=0, ready=1, told_preg=0, and the table is unchanged.
REQ-033 Assert reset together with rename and rewind -> tables return to identity mapping.

Source files
------------

// File: rtl/map_table.sv
// Two-wide register rename map: speculative {preg, ready} table with CDB wakeup,
// an architectural table updated at retire, and single-cycle rewind to architectural state.
module map_table #(
    parameter int NUM_AREGS = 32,
    parameter int NUM_PREGS = 64,
    parameter int PREG_W    = 6,
    parameter int AREG_W    = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             rename_valid,
    input  logic [1:0][AREG_W-1:0] dest_areg,
    input  logic [1:0][AREG_W-1:0] src1_areg,
    input  logic [1:0][AREG_W-1:0] src2_areg,
    input  logic [1:0][PREG_W-1:0] new_preg,
    output logic [1:0][PREG_W-1:0] src1_preg,
    output logic [1:0][PREG_W-1:0] src2_preg,
    output logic [1:0]             src1_ready,
    output logic [1:0]             src2_ready,
    output logic [1:0][PREG_W-1:0] told_preg,
    input  logic                   cdb_valid,
    input  logic [PREG_W-1:0]      cdb_preg,
    input  logic [1:0]             retire_valid,
    input  logic [1:0][AREG_W-1:0] retire_areg,
    input  logic [1:0][PREG_W-1:0] retire_preg,
    input  logic                   rewind
);

    localparam logic [AREG_W-1:0] AREG_ZERO = {AREG_W{1'b0}};
    localparam logic [PREG_W-1:0] PREG_ZERO = {PREG_W{1'b0}};

    if ((NUM_AREGS > (1 << AREG_W)) || (NUM_PREGS > (1 << PREG_W)) || (NUM_AREGS > NUM_PREGS)) begin : g_bad_params
        $error("map_table: inconsistent table / tag width parameters");
    end

    logic [PREG_W-1:0] spec_preg_r [NUM_AREGS];
    logic              spec_rdy_r  [NUM_AREGS];
    logic [PREG_W-1:0] arch_preg_r [NUM_AREGS];
    logic [PREG_W-1:0] spec_preg_nxt_s [NUM_AREGS];
    logic              spec_rdy_nxt_s  [NUM_AREGS];
    logic [PREG_W-1:0] arch_preg_nxt_s [NUM_AREGS];
    logic [1:0]        wr_en_s;
    logic              fwd1_s;
    logic              fwd2_s;

    // Resolve one source: areg 0 is hardwired, then older-slot forward, then table with CDB bypass.
    function automatic logic [PREG_W:0] resolve_src(
        input logic [AREG_W-1:0] areg,
        input logic [PREG_W-1:0] tbl_preg,
        input logic              tbl_rdy,
        input logic              fwd,
        input logic [PREG_W-1:0] fwd_preg,
        input logic              cdb_v,
        input logic [PREG_W-1:0] cdb_p
    );
        logic [PREG_W:0] res;
        if (areg == AREG_ZERO) begin
            res = {PREG_ZERO, 1'b1};
        end else if (fwd) begin
            res = {fwd_preg, 1'b0};
        end else begin
            res = {tbl_preg, tbl_rdy | (cdb_v & (cdb_p == tbl_preg))};
        end
        return res;
    endfunction

    // Renames that actually allocate (areg 0 never does)
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wr_en_s[i] = rename_valid[i] & (dest_areg[i] != AREG_ZERO);
        end
    end

    // Source lookup for both slots
    always_comb begin
        fwd1_s = 1'b0;
        fwd2_s = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fwd1_s = (i == 1) && wr_en_s[0] && (src1_areg[i] == dest_areg[0]);
            fwd2_s = (i == 1) && wr_en_s[0] && (src2_areg[i] == dest_areg[0]);
            {src1_preg[i], src1_ready[i]} = resolve_src(src1_areg[i], spec_preg_r[src1_areg[i]],
                spec_rdy_r[src1_areg[i]], fwd1_s, new_preg[0], cdb_valid, cdb_preg);
            {src2_preg[i], src2_ready[i]} = resolve_src(src2_areg[i], spec_preg_r[src2_areg[i]],
                spec_rdy_r[src2_areg[i]], fwd2_s, new_preg[0], cdb_valid, cdb_preg);
        end
    end

    // Previous mapping of each destination, seeing slot 0's rename from slot 1
    always_comb begin
        if (dest_areg[0] == AREG_ZERO) begin
            told_preg[0] = PREG_ZERO;
        end else begin
            told_preg[0] = spec_preg_r[dest_areg[0]];
        end
        if (dest_areg[1] == AREG_ZERO) begin
            told_preg[1] = PREG_ZERO;
        end else if (rename_valid[0] && (dest_areg[1] == dest_areg[0])) begin
            told_preg[1] = new_preg[0];
        end else begin
            told_preg[1] = spec_preg_r[dest_areg[1]];
        end
    end

    // Next-state for both tables; slot 1 beats slot 0, rename beats CDB wakeup
    always_comb begin
        for (int j = 0; j < NUM_AREGS; j++) begin
            if ((j != 0) && retire_valid[1] && (retire_areg[1] == AREG_W'(j))) begin
                arch_preg_nxt_s[j] = retire_preg[1];
            end else if ((j != 0) && retire_valid[0] && (retire_areg[0] == AREG_W'(j))) begin
                arch_preg_nxt_s[j] = retire_preg[0];
            end else begin
                arch_preg_nxt_s[j] = arch_preg_r[j];
            end

            if (rewind) begin
                spec_preg_nxt_s[j] = arch_preg_nxt_s[j];
                spec_rdy_nxt_s[j]  = 1'b1;
            end else if (wr_en_s[1] && (dest_areg[1] == AREG_W'(j))) begin
                spec_preg_nxt_s[j] = new_preg[1];
                spec_rdy_nxt_s[j]  = 1'b0;
            end else if (wr_en_s[0] && (dest_areg[0] == AREG_W'(j))) begin
                spec_preg_nxt_s[j] = new_preg[0];
                spec_rdy_nxt_s[j]  = 1'b0;
            end else begin
                spec_preg_nxt_s[j] = spec_preg_r[j];
                spec_rdy_nxt_s[j]  = spec_rdy_r[j] | (cdb_valid & (cdb_preg == spec_preg_r[j]));
            end
        end
    end

    // Table state: identity mapping on reset
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int j = 0; j < NUM_AREGS; j++) begin
                spec_preg_r[j] <= PREG_W'(j);
                spec_rdy_r[j]  <= 1'b1;
                arch_preg_r[j] <= PREG_W'(j);
            end
        end else begin
            for (int j = 0; j < NUM_AREGS; j++) begin
                spec_preg_r[j] <= spec_preg_nxt_s[j];
                spec_rdy_r[j]  <= spec_rdy_nxt_s[j];
                arch_preg_r[j] <= arch_preg_nxt_s[j];
            end
        end
    end

endmodule

// File: tb/tb_map_table.sv
// Directed bench for map_table: expectations are queued when stimulus is applied
// and popped against the DUT outputs before the next rising edge.
module tb_map_table;

    logic             clock;
    logic             reset;
    logic [1:0]       rename_valid;
    logic [1:0][4:0]  dest_areg;
    logic [1:0][4:0]  src1_areg;
    logic [1:0][4:0]  src2_areg;
    logic [1:0][5:0]  new_preg;
    logic [1:0][5:0]  src1_preg;
    logic [1:0][5:0]  src2_preg;
    logic [1:0]       src1_ready;
    logic [1:0]       src2_ready;
    logic [1:0][5:0]  told_preg;
    logic             cdb_valid;
    logic [5:0]       cdb_preg;
    logic [1:0]       retire_valid;
    logic [1:0][4:0]  retire_areg;
    logic [1:0][5:0]  retire_preg;
    logic             rewind;

    int          errors = 0;
    int          checks = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    map_table dut (
        .clock(clock), .reset(reset), .rename_valid(rename_valid), .dest_areg(dest_areg),
        .src1_areg(src1_areg), .src2_areg(src2_areg), .new_preg(new_preg),
        .src1_preg(src1_preg), .src2_preg(src2_preg), .src1_ready(src1_ready),
        .src2_ready(src2_ready), .told_preg(told_preg), .cdb_valid(cdb_valid),
        .cdb_preg(cdb_preg), .retire_valid(retire_valid), .retire_areg(retire_areg),
        .retire_preg(retire_preg), .rewind(rewind)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic expect_val(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic chk(input logic [31:0] obs);
        string       tag;
        logic [31:0] expv;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0d with no expected entry", obs);
        end else begin
            tag  = tag_q.pop_front();
            expv = exp_q.pop_front();
            assert (obs === expv) else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        rename_valid = 2'b00; dest_areg = '{5'd0, 5'd0}; new_preg = '{6'd0, 6'd0};
        src1_areg = '{5'd0, 5'd0}; src2_areg = '{5'd0, 5'd0};
        cdb_valid = 1'b0; cdb_preg = 6'd0;
        retire_valid = 2'b00; retire_areg = '{5'd0, 5'd0}; retire_preg = '{6'd0, 6'd0};
        rewind = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // reset state is visible on the first cycle
        src1_areg[0] = 5'd5; src2_areg[1] = 5'd31; dest_areg[0] = 5'd9;
        expect_val("rst_r5_preg", 32'd5); expect_val("rst_r5_rdy", 32'd1);
        expect_val("rst_r31_preg", 32'd31); expect_val("rst_told_r9", 32'd9);
        #2;
        chk(32'(src1_preg[0])); chk(32'(src1_ready[0]));
        chk(32'(src2_preg[1])); chk(32'(told_preg[0]));
        tick();

        // intra-group forwarding and told_preg for same dest in both slots
        idle();
        rename_valid = 2'b11; dest_areg[0] = 5'd3; new_preg[0] = 6'd40;
        dest_areg[1] = 5'd3; new_preg[1] = 6'd41; src1_areg[1] = 5'd3; src2_areg[0] = 5'd3;
        expect_val("fwd_s1_preg", 32'd40); expect_val("fwd_s1_rdy", 32'd0);
        expect_val("fwd_told0", 32'd3); expect_val("fwd_told1", 32'd40);
        expect_val("fwd_s0_src2_preg", 32'd3);
        #2;
        chk(32'(src1_preg[1])); chk(32'(src1_ready[1]));
        chk(32'(told_preg[0])); chk(32'(told_preg[1])); chk(32'(src2_preg[0]));
        tick();

        // slot 1 wins; then slot 0 invalid must not forward
        idle();
        src1_areg[0] = 5'd3;
        expect_val("r3_after_pair", 32'd41); expect_val("r3_after_pair_rdy", 32'd0);
        #2;
        chk(32'(src1_preg[0])); chk(32'(src1_ready[0]));
        rename_valid = 2'b10; dest_areg[0] = 5'd3; new_preg[0] = 6'd55;
        dest_areg[1] = 5'd3; new_preg[1] = 6'd42; src1_areg[1] = 5'd3;
        expect_val("nofwd_s1_preg", 32'd41); expect_val("nofwd_told1", 32'd41);
        #2;
        chk(32'(src1_preg[1])); chk(32'(told_preg[1]));
        tick();

        // CDB wakeup: bypass in the broadcast cycle, table bit set afterwards
        idle();
        rename_valid = 2'b01; dest_areg[0] = 5'd7; new_preg[0] = 6'd50;
        tick();
        idle();
        cdb_valid = 1'b1; cdb_preg = 6'd50; src1_areg[0] = 5'd7; src2_areg[0] = 5'd3;
        expect_val("cdb_bypass_preg", 32'd50); expect_val("cdb_bypass_rdy", 32'd1);
        expect_val("r3_slot1_only_preg", 32'd42); expect_val("r3_not_woken", 32'd0);
        #2;
        chk(32'(src1_preg[0])); chk(32'(src1_ready[0]));
        chk(32'(src2_preg[0])); chk(32'(src2_ready[0]));
        tick();
        idle();
        src1_areg[0] = 5'd7;
        expect_val("cdb_table_rdy", 32'd1);
        #2;
        chk(32'(src1_ready[0]));

        // rename and CDB to the same preg in one cycle leaves ready clear
        rename_valid = 2'b01; dest_areg[0] = 5'd8; new_preg[0] = 6'd60;
        cdb_valid = 1'b1; cdb_preg = 6'd60;
        tick();
        idle();
        src1_areg[0] = 5'd8;
        expect_val("ren_cdb_same_preg", 32'd60); expect_val("ren_cdb_same_rdy", 32'd0);
        #2;
        chk(32'(src1_preg[0])); chk(32'(src1_ready[0]));

        // retire then rewind restores committed mapping
        rename_valid = 2'b01; dest_areg[0] = 5'd4; new_preg[0] = 6'd45;
        tick();
        idle();
        retire_valid = 2'b01; retire_areg[0] = 5'd4; retire_preg[0] = 6'd45;
        rename_valid = 2'b01; dest_areg[0] = 5'd4; new_preg[0] = 6'd46;
        tick();
        idle();
        src1_areg[0] = 5'd4;
        expect_val("r4_spec_46", 32'd46);
        #2;
        chk(32'(src1_preg[0]));
        rewind = 1'b1;
        retire_valid = 2'b11; retire_areg[0] = 5'd10; retire_preg[0] = 6'd20;
        retire_areg[1] = 5'd10; retire_preg[1] = 6'd21;
        rename_valid = 2'b01; dest_areg[0] = 5'd4; new_preg[0] = 6'd47;
        cdb_valid = 1'b1; cdb_preg = 6'd46;
        tick();
        idle();
        src1_areg[0] = 5'd4; src2_areg[0] = 5'd3; src1_areg[1] = 5'd10; src2_areg[1] = 5'd7;
        expect_val("rewind_r4_preg", 32'd45); expect_val("rewind_r4_rdy", 32'd1);
        expect_val("rewind_r3_preg", 32'd3); expect_val("rewind_r10_slot1_wins", 32'd21);
        expect_val("rewind_r7_preg", 32'd7); expect_val("rewind_r7_rdy", 32'd1);
        #2;
        chk(32'(src1_preg[0])); chk(32'(src1_ready[0])); chk(32'(src2_preg[0]));
        chk(32'(src1_preg[1])); chk(32'(src2_preg[1])); chk(32'(src2_ready[1]));

        // areg 0 never renames and always reads preg 0 ready
        rename_valid = 2'b01; dest_areg[0] = 5'd0; new_preg[0] = 6'd63;
        cdb_valid = 1'b0; src1_areg[0] = 5'd0; src2_areg[0] = 5'd0; src1_areg[1] = 5'd0;
        expect_val("r0_src1_preg", 32'd0); expect_val("r0_src1_rdy", 32'd1);
        expect_val("r0_src2_preg", 32'd0); expect_val("r0_told", 32'd0);
        expect_val("r0_slot1_nofwd", 32'd0);
        #2;
        chk(32'(src1_preg[0])); chk(32'(src1_ready[0])); chk(32'(src2_preg[0]));
        chk(32'(told_preg[0])); chk(32'(src1_preg[1]));
        tick();
        idle();
        src1_areg[0] = 5'd0; src2_areg[0] = 5'd5;
        expect_val("r0_after_preg", 32'd0); expect_val("r0_after_rdy", 32'd1);
        expect_val("r5_unchanged", 32'd5);
        #2;
        chk(32'(src1_preg[0])); chk(32'(src1_ready[0])); chk(32'(src2_preg[0]));

        // reset overrides rename, retire and rewind in the same cycle
        reset = 1'b1; rewind = 1'b1;
        rename_valid = 2'b01; dest_areg[0] = 5'd5; new_preg[0] = 6'd61;
        retire_valid = 2'b01; retire_areg[0] = 5'd9; retire_preg[0] = 6'd33;
        tick();
        reset = 1'b0;
        idle();
        src1_areg[0] = 5'd5; src2_areg[0] = 5'd4; src1_areg[1] = 5'd10; src2_areg[1] = 5'd3;
        expect_val("rst2_r5", 32'd5); expect_val("rst2_r5_rdy", 32'd1);
        expect_val("rst2_r4", 32'd4); expect_val("rst2_r10", 32'd10); expect_val("rst2_r3", 32'd3);
        #2;
        chk(32'(src1_preg[0])); chk(32'(src1_ready[0])); chk(32'(src2_preg[0]));
        chk(32'(src1_preg[1])); chk(32'(src2_preg[1]));
        // architectural table also reset: rewind lands on identity
        rewind = 1'b1;
        tick();
        idle();
        src1_areg[0] = 5'd9; src2_areg[0] = 5'd4;
        expect_val("rst2_arch_r9", 32'd9); expect_val("rst2_arch_r4", 32'd4);
        #2;
        chk(32'(src1_preg[0])); chk(32'(src2_preg[0]));

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
